// File: rtl/gcd_binary_p.sv
// Binary (Stein) GCD with a valid/ready operand port and a valid/ready result port.
// One reduction step per RUN cycle; the RUN-cycle count is reported alongside the result.
module gcd_binary_p #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CW-1:0]    cycles,
  output logic             zero_err
);

  // k never exceeds WIDTH-1 for nonzero operands.
  localparam int unsigned KW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0]    CycOne = CW'(1);
  localparam logic [KW-1:0]    KOne   = KW'(1);
  localparam logic [WIDTH-1:0] Zero   = '0;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [KW-1:0]    k_q;

  logic [WIDTH-1:0] a_minus_b;
  logic [WIDTH-1:0] b_minus_a;
  logic             a_even;
  logic             b_even;
  logic             a_gt_b;
  logic             a_in_zero;
  logic             b_in_zero;

  // Only the subtraction matching the comparison is used, so neither wraps.
  assign a_minus_b = a_q - b_q;
  assign b_minus_a = b_q - a_q;
  assign a_even    = ~a_q[0];
  assign b_even    = ~b_q[0];
  assign a_gt_b    = a_q > b_q;
  assign a_in_zero = a_in == Zero;
  assign b_in_zero = b_in == Zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      gcd_out   <= '0;
      cycles    <= '0;
      zero_err  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= a_in;
            b_q      <= b_in;
            k_q      <= '0;
            cycles   <= '0;
            zero_err <= 1'b0;
            in_ready <= 1'b0;
            if (a_in_zero || b_in_zero) begin
              gcd_out   <= a_in | b_in;
              zero_err  <= a_in_zero && b_in_zero;
              out_valid <= 1'b1;
              state_q   <= StDone;
            end else begin
              state_q <= StRun;
            end
          end
        end

        StRun: begin
          if (cycles != '1) begin
            cycles <= cycles + CycOne;
          end
          if (a_q == b_q) begin
            gcd_out   <= a_q << k_q;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else if (a_even && b_even) begin
            a_q <= a_q >> 1;
            b_q <= b_q >> 1;
            k_q <= k_q + KOne;
          end else if (a_even) begin
            a_q <= a_q >> 1;
          end else if (b_even) begin
            b_q <= b_q >> 1;
          end else if (a_gt_b) begin
            a_q <= a_minus_b >> 1;
          end else begin
            b_q <= b_minus_a >> 1;
          end
        end

        StDone: begin
          // in_ready rises only after the handshake edge, so no accept shares it.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end

        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_binary_p.sv
// Self-checking bench for gcd_binary_p: directed cases plus randomized operands
// compared against a Euclid-based reference and a step-count model.
module tb_gcd_binary_p;

  logic        clk;
  logic        reset;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] gcd_out;
  logic [7:0]  cycles;
  logic        zero_err;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [15:0] s_a_in;
  logic [15:0] s_b_in;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [15:0] s_gcd_out;
  logic [3:0]  s_cycles;
  logic        s_zero_err;

  int checks;
  int errors;

  gcd_binary_p #(.WIDTH(16), .CW(8)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .gcd_out  (gcd_out),
    .cycles   (cycles),
    .zero_err (zero_err)
  );

  gcd_binary_p #(.WIDTH(16), .CW(4)) u_sat (
    .clk      (clk),
    .reset    (reset),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .a_in     (s_a_in),
    .b_in     (s_b_in),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .gcd_out  (s_gcd_out),
    .cycles   (s_cycles),
    .zero_err (s_zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
    int unsigned x = a;
    int unsigned y = b;
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Number of RUN steps the reduction rules take, unsaturated.
  function automatic int unsigned ref_steps(input int unsigned a0, input int unsigned b0);
    int unsigned a = a0;
    int unsigned b = b0;
    int unsigned n = 0;
    if (a == 0 || b == 0) return 0;
    forever begin
      n++;
      if (a == b) break;
      if (a % 2 == 0 && b % 2 == 0) begin
        a = a / 2;
        b = b / 2;
      end else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a > b) a = (a - b) / 2;
      else b = (b - a) / 2;
    end
    return n;
  endfunction

  // Offers one pair, waits (bounded) for the result, returns it and completes the handshake.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] g, output logic [7:0] c, output logic z,
                       output int edges);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    edges    = 0;
    while (!out_valid && edges < 300) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    g = gcd_out;
    c = cycles;
    z = zero_err;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || gcd_out !== 16'd0 ||
        cycles !== 8'd0 || zero_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b ov=%b g=%0d c=%0d z=%b, want 1 0 0 0 0",
               in_ready, out_valid, gcd_out, cycles, zero_err);
    end
    checks++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_cycles !== 4'd0) begin
      errors++;
      $display("FAIL reset_state_sat: got rdy=%b ov=%b c=%0d, want 1 0 0",
               s_in_ready, s_out_valid, s_cycles);
    end
  endtask

  task automatic test_basic();
    logic [15:0] g;
    logic [7:0]  c;
    logic        z;
    int          e;
    do_op(16'd48, 16'd18, g, c, z, e);
    checks++;
    if (g !== 16'd6 || c !== 8'd6 || z !== 1'b0 || e != 6) begin
      errors++;
      $display("FAIL basic_48_18: got g=%0d c=%0d z=%b edges=%0d, want 6 6 0 6", g, c, z, e);
    end
  endtask

  task automatic test_zero();
    logic [15:0] g;
    logic [7:0]  c;
    logic        z;
    int          e;
    do_op(16'd0, 16'd7, g, c, z, e);
    checks++;
    if (g !== 16'd7 || c !== 8'd0 || z !== 1'b0 || e != 0) begin
      errors++;
      $display("FAIL zero_0_7: got g=%0d c=%0d z=%b edges=%0d, want 7 0 0 0", g, c, z, e);
    end
    do_op(16'd9, 16'd0, g, c, z, e);
    checks++;
    if (g !== 16'd9 || c !== 8'd0 || z !== 1'b0 || e != 0) begin
      errors++;
      $display("FAIL zero_9_0: got g=%0d c=%0d z=%b edges=%0d, want 9 0 0 0", g, c, z, e);
    end
    do_op(16'd0, 16'd0, g, c, z, e);
    checks++;
    if (g !== 16'd0 || c !== 8'd0 || z !== 1'b1 || e != 0) begin
      errors++;
      $display("FAIL zero_0_0: got g=%0d c=%0d z=%b edges=%0d, want 0 0 1 0", g, c, z, e);
    end
  endtask

  task automatic test_equal();
    logic [15:0] g;
    logic [7:0]  c;
    logic        z;
    int          e;
    do_op(16'd5, 16'd5, g, c, z, e);
    checks++;
    if (g !== 16'd5 || c !== 8'd1 || z !== 1'b0) begin
      errors++;
      $display("FAIL equal_5_5: got g=%0d c=%0d z=%b, want 5 1 0", g, c, z);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] g;
    logic [7:0]  c;
    logic        z;
    int          e;
    int          n;
    // Wide counter shows the true step count.
    do_op(16'hFFFF, 16'd1, g, c, z, e);
    checks++;
    if (g !== 16'd1 || int'(c) != ref_steps(65535, 1)) begin
      errors++;
      $display("FAIL nosat_65535_1: got g=%0d c=%0d, want 1 %0d", g, c, ref_steps(65535, 1));
    end
    @(negedge clk);
    s_in_valid = 1'b1;
    s_a_in     = 16'hFFFF;
    s_b_in     = 16'd1;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    n = 0;
    while (!s_out_valid && n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    checks++;
    if (s_gcd_out !== 16'd1 || s_cycles !== 4'd15 || n != ref_steps(65535, 1)) begin
      errors++;
      $display("FAIL sat_65535_1: got g=%0d c=%0d edges=%0d, want 1 15 %0d",
               s_gcd_out, s_cycles, n, ref_steps(65535, 1));
    end
    s_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_out_ready = 1'b0;
    checks++;
    if (s_out_valid !== 1'b0 || s_cycles !== 4'd15) begin
      errors++;
      $display("FAIL sat_release: got ov=%b c=%0d, want 0 15", s_out_valid, s_cycles);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    logic [15:0] g;
    logic [7:0]  c;
    logic        z;
    int          e;
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = 16'd48;
    b_in     = 16'd18;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    // Offer a different pair while DONE holds; it must be ignored until IDLE.
    a_in = 16'd9;
    b_in = 16'd6;
    bad  = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || gcd_out !== 16'd6 || in_ready !== 1'b0 || cycles !== 8'd6)
        bad++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || n != 6) begin
      errors++;
      $display("FAIL backpressure_hold: got %0d unstable cycles, edges=%0d, want 0 6", bad, n);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: got ov=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_accept: got rdy=%b, want 0", in_ready);
    end
    e = 0;
    while (!out_valid && e < 300) begin
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    g = gcd_out;
    c = cycles;
    z = zero_err;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (g !== 16'd3 || int'(c) != ref_steps(9, 6) || z !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_9_6: got g=%0d c=%0d z=%b, want 3 %0d 0",
               g, c, z, ref_steps(9, 6));
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] g;
    logic [7:0]  c;
    logic        z;
    int          e;
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = 16'd48;
    b_in     = 16'd18;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || gcd_out !== 16'd0 || in_ready !== 1'b1 || cycles !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got ov=%b g=%0d rdy=%b c=%0d, want 0 0 1 0",
               out_valid, gcd_out, in_ready, cycles);
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: got ov=%b, want 0", out_valid);
    end
    do_op(16'd12, 16'd8, g, c, z, e);
    checks++;
    if (g !== 16'd4 || int'(c) != ref_steps(12, 8)) begin
      errors++;
      $display("FAIL after_reset_12_8: got g=%0d c=%0d, want 4 %0d", g, c, ref_steps(12, 8));
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;
    logic [7:0]  c;
    logic        z;
    int          e;
    int unsigned exp_g;
    int unsigned exp_c;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom) >> $urandom_range(0, 15);
      b = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) a = 16'd0;
      if ($urandom_range(0, 3) == 0) b = a << $urandom_range(0, 3);
      exp_g = ref_gcd(a, b);
      exp_c = ref_steps(a, b);
      if (exp_c > 255) exp_c = 255;
      do_op(a, b, g, c, z, e);
      checks++;
      if (int'(g) != exp_g || int'(c) != exp_c || z !== (a == 0 && b == 0) ||
          e != ref_steps(a, b)) begin
        errors++;
        $display("FAIL random_%0d (%0d,%0d): got g=%0d c=%0d z=%b edges=%0d, want %0d %0d %b %0d",
                 i, a, b, g, c, z, e, exp_g, exp_c, (a == 0 && b == 0), ref_steps(a, b));
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    a_in        = '0;
    b_in        = '0;
    out_ready   = 1'b0;
    s_in_valid  = 1'b0;
    s_a_in      = '0;
    s_b_in      = '0;
    s_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_equal();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
